// File: rtl/spi_xfer_ctrl.sv
// Multi-byte SPI mode-0 transfer sequencer driven by an external 100 kHz divisor.
// Define SPI_XFER_CTRL_LOOPBACK_EN to feed the rx path from mosi internally.
module spi_xfer_ctrl #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BYTES = 16,
  parameter int unsigned GAP_EDGES = 2,
  parameter int unsigned CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  n_bytes_i,
  input  logic              tx_valid_i,
  input  logic [DATA_W-1:0] tx_data_i,
  output logic              tx_ready_o,
  output logic              rx_valid_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              div_en_o,
  input  logic              div_sclk_i,
  input  logic              div_pos_i,
  input  logic              div_neg_i,
  output logic              cs_n_o,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StShift = 3'd2;
  localparam logic [2:0] StGap   = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  localparam int unsigned BitW = $clog2(DATA_W + 1);
  localparam int unsigned GapW = $clog2(GAP_EDGES + 1);

  localparam logic [BitW-1:0]  LastBit = BitW'(DATA_W - 1);
  localparam logic [BitW-1:0]  FullBits = BitW'(DATA_W);
  localparam logic [GapW-1:0]  GapLast = GapW'(GAP_EDGES - 1);
  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_BYTES);

  logic [2:0]        state_q, state_d;
  logic              cs_n_q, cs_n_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-2:0] rx_sr_q, rx_sr_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  bytes_left_q, bytes_left_d;
  logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
  logic              rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_bit;

`ifdef SPI_XFER_CTRL_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = miso_i;
  assign rx_bit      = tx_sr_q[DATA_W-1];
`else
  assign rx_bit      = miso_i;
`endif

  always_comb begin
    state_d      = state_q;
    cs_n_d       = cs_n_q;
    tx_sr_d      = tx_sr_q;
    rx_sr_d      = rx_sr_q;
    bit_cnt_d    = bit_cnt_q;
    bytes_left_d = bytes_left_q;
    gap_cnt_d    = gap_cnt_q;
    rx_valid_d   = 1'b0;
    rx_data_d    = rx_data_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          if (n_bytes_i == '0) begin
            state_d = StDone;
          end else begin
            state_d      = StLoad;
            bytes_left_d = (n_bytes_i > MaxCnt) ? MaxCnt : n_bytes_i;
          end
        end
      end
      StLoad: begin
        // Divisor is paused here, so an underrun just stretches the byte gap.
        if (tx_valid_i) begin
          tx_sr_d   = tx_data_i;
          cs_n_d    = 1'b0;
          bit_cnt_d = '0;
          state_d   = StShift;
        end
      end
      StShift: begin
        if (div_pos_i) begin
          rx_sr_d   = {rx_sr_q[DATA_W-3:0], rx_bit};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LastBit) begin
            rx_valid_d = 1'b1;
            rx_data_d  = {rx_sr_q, rx_bit};
          end
        end else if (div_neg_i) begin
          if (bit_cnt_q == FullBits) begin
            bytes_left_d = bytes_left_q - 1'b1;
            bit_cnt_d    = '0;
            if (bytes_left_q == CNT_W'(1)) begin
              state_d   = StGap;
              cs_n_d    = 1'b1;
              tx_sr_d   = '0;
              gap_cnt_d = '0;
            end else begin
              state_d = StLoad;
            end
          end else begin
            tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
          end
        end
      end
      StGap: begin
        if (div_neg_i && !div_pos_i) begin
          if (gap_cnt_q == GapLast) begin
            state_d = StDone;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= StIdle;
      cs_n_q       <= 1'b1;
      tx_sr_q      <= '0;
      rx_sr_q      <= '0;
      bit_cnt_q    <= '0;
      bytes_left_q <= '0;
      gap_cnt_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      cs_n_q       <= cs_n_d;
      tx_sr_q      <= tx_sr_d;
      rx_sr_q      <= rx_sr_d;
      bit_cnt_q    <= bit_cnt_d;
      bytes_left_q <= bytes_left_d;
      gap_cnt_q    <= gap_cnt_d;
      rx_valid_q   <= rx_valid_d;
      rx_data_q    <= rx_data_d;
    end
  end

  assign tx_ready_o = (state_q == StLoad);
  assign busy_o     = (state_q == StLoad) || (state_q == StShift) || (state_q == StGap);
  assign done_o     = (state_q == StDone);
  assign div_en_o   = (state_q == StShift) || (state_q == StGap);
  assign sclk_o     = (state_q == StShift) && div_sclk_i;
  assign cs_n_o     = cs_n_q;
  assign mosi_o     = tx_sr_q[DATA_W-1];
  assign rx_valid_o = rx_valid_q;
  assign rx_data_o  = rx_data_q;

endmodule
